hit_resolver: RTL
=================

# hit_resolver

Parametrised successor to the per-frame collision checker. It sits between the two character FSMs and the game controller. It evaluates body collision and directional attack hitboxes against hurtboxes every clock, and enforces one hit per attack active phase. It owns the hitstun and blockstun frame countdowns, so the controller receives ready-made stun states and one-cycle hit events instead of raw level flags.

## Interface
- POS_W, 10: position bus width.
- CHAR_WIDTH, 128: hurtbox/body width in pixels.
- BODY_GAP, 5: minimum pixel gap between bodies before collision_flag asserts.
- ATK_REACH, 64: hitbox length of neutral attack, measured from the attacker's front edge.
- DIR_ATK_REACH, 96: hitbox length of directional attack.
- HITSTUN_FRAMES, 12: stun length loaded on a clean hit.
- BLOCKSTUN_FRAMES, 6: stun length loaded on a blocked hit.
- CNT_W, 5: stun counter width; both *_FRAMES values must be < 2^CNT_W.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- char1_pos_x, char2_pos_x  in  POS_W  left edge of each character. char1 is always on the left.
- char1_state, char2_state  in  4  character FSM state, using the shared 4-bit encoding: IDLE=0, ATTACK_ACTIVE=4, ATTACK_DIR_ACTIVE=7, STUN=9.
- char1_block_flag, char2_block_flag  in  1  defender is holding block.
- collision_flag  out  1  registered body-contact flag.
- char1_frame_state, char2_frame_state  out  2  NOHIT=00, HITSTUN=01, BLOCKSTUN=10.
- char1_stun_cnt, char2_stun_cnt  out  CNT_W  remaining stun frames.
- char1_hit_o, char2_hit_o  out  1  one-cycle pulse: this character landed a hit (clean or blocked).
- char1_combo, char2_combo  out  4  present only with HIT_COMBO_EN.

## Operation
- Arithmetic is done at POS_W+2 bits, unsigned, with no subtraction on positions. Underflow and overflow are therefore impossible.
- Body collision: char1_pos_x + CHAR_WIDTH + BODY_GAP >= char2_pos_x.
- Attack detection: reach = ATK_REACH when the state is ATTACK_ACTIVE, DIR_ATK_REACH when it is ATTACK_DIR_ACTIVE. A character in any other state has no hitbox.
- raw1 (char1 attacking char2): char1_pos_x + CHAR_WIDTH + reach1 > char2_pos_x.
- raw2 (char2 attacking char1): char2_pos_x < char1_pos_x + CHAR_WIDTH + reach2.
- Hit lockout: latchN sets when charN lands a hit. latchN clears on any cycle where charN_state is neither active state. A raw hit with its latch set is ignored.
- Defender eligibility: the defender's stun counter must be 0 and its state must not be STUN. Otherwise the raw hit is ignored and the latch is not set.
- Valid hit: validN = rawN & ~latchN & eligible(defender).
- Trade (valid1 & valid2 in the same cycle): both counters load HITSTUN_FRAMES, block is ignored, and both hit pulses fire.
- Single hit: the defender counter loads BLOCKSTUN_FRAMES if the defender's block_flag is set, else HITSTUN_FRAMES.
- Counter per character: a load has priority over a decrement. Otherwise it decrements on frame_tick while nonzero, and saturates at 0.
- Stun type: a per-character kind register records HIT or BLOCK at load time.
- frame_state: NOHIT when the counter is 0, otherwise the recorded kind.

## Timing
- Reset value of every output is 0; latches, counters and kind registers also reset to 0.
- Inputs sampled at edge N drive all outputs after edge N (1-cycle latency); there is no combinational input-to-output path.
- A hit pulse is high for exactly one cycle, the same cycle the counter shows its loaded value.
- A frame_tick while the counter is 1 gives counter 0 and frame_state NOHIT after the same edge.
- Mid-stun reset returns everything to 0 immediately (asynchronous). Deassertion is synchronised externally.
- Position changes while stunned do not affect the counters.

## Configuration
- HIT_COMBO_EN defined:
  - charN_combo counts consecutive hits charN lands.
  - It increments, saturating at 15, when a valid hit lands while the defender's counter is 0 and the defender's stun ended at most 2 frame_ticks earlier. A per-defender 2-bit "since-stun" counter tracks this.
  - Otherwise a valid hit sets the combo to 1.
  - Trades reset both combos to 0.
- HIT_COMBO_EN undefined: the combo ports and logic are absent.

## Test plan
- Reach boundary:
  - pos 0/192, char1 ATTACK_ACTIVE, reach 64 (0+128+64 = 192, not > 192) -> no hit.
  - pos 0/191 -> char1_hit_o pulse, char2_stun_cnt = 12, char2_frame_state = 01.
- Block: as above with char2_block_flag = 1 -> char2_stun_cnt = 6, state 10. Then 6 frame_ticks -> state 00 exactly after the 6th tick.
- Lockout: char1 held ATTACK_ACTIVE for 40 cycles with 13 ticks -> only one hit pulse. Return to IDLE for one cycle and re-enter ACTIVE -> a second hit lands.
- Trade: both DIR_ACTIVE at pos 100/300, char2 blocking -> both counters 12, both states 01, both pulses fire.
- Priority/reset:
  - A load coincident with frame_tick -> counter = the loaded value.
  - Assert rst_n low mid-stun -> all outputs 0 without a clock edge.
- HIT_COMBO_EN: char1 hits, char2 stun expires, char1 re-hits 1 tick later -> char1_combo = 2. Re-hit 3 ticks later instead -> char1_combo = 1.

Source files
------------

// File: rtl/hit_resolver_if.sv
// Bundle between the two character FSMs, the game controller and hit_resolver.
// Combo counters exist only when HIT_COMBO_EN is defined.
interface hit_resolver_if #(
  parameter int POS_W = 10,
  parameter int CNT_W = 5
);
  logic             frame_tick;
  logic [POS_W-1:0] char1_pos_x;
  logic [POS_W-1:0] char2_pos_x;
  logic [3:0]       char1_state;
  logic [3:0]       char2_state;
  logic             char1_block_flag;
  logic             char2_block_flag;
  logic             collision_flag;
  logic [1:0]       char1_frame_state;
  logic [1:0]       char2_frame_state;
  logic [CNT_W-1:0] char1_stun_cnt;
  logic [CNT_W-1:0] char2_stun_cnt;
  logic             char1_hit_o;
  logic             char2_hit_o;
`ifdef HIT_COMBO_EN
  logic [3:0]       char1_combo;
  logic [3:0]       char2_combo;
`endif

  modport master (
    output frame_tick, char1_pos_x, char2_pos_x, char1_state, char2_state,
           char1_block_flag, char2_block_flag,
    input  collision_flag, char1_frame_state, char2_frame_state,
           char1_stun_cnt, char2_stun_cnt, char1_hit_o, char2_hit_o
`ifdef HIT_COMBO_EN
    , input char1_combo, char2_combo
`endif
  );

  modport slave (
    input  frame_tick, char1_pos_x, char2_pos_x, char1_state, char2_state,
           char1_block_flag, char2_block_flag,
    output collision_flag, char1_frame_state, char2_frame_state,
           char1_stun_cnt, char2_stun_cnt, char1_hit_o, char2_hit_o
`ifdef HIT_COMBO_EN
    , output char1_combo, char2_combo
`endif
  );
endinterface

// File: rtl/hit_resolver.sv
// Body/attack collision, one-hit-per-active-phase lockout and hit/block stun countdowns.
// Define HIT_COMBO_EN to add per-character consecutive-hit combo counters.
module hit_resolver #(
  parameter int POS_W            = 10,
  parameter int CHAR_WIDTH       = 128,
  parameter int BODY_GAP         = 5,
  parameter int ATK_REACH        = 64,
  parameter int DIR_ATK_REACH    = 96,
  parameter int HITSTUN_FRAMES   = 12,
  parameter int BLOCKSTUN_FRAMES = 6,
  parameter int CNT_W            = 5
) (
  input logic          clk,
  input logic          rst_n,
  hit_resolver_if.slave bus
);
  typedef enum logic [3:0] {
    ST_IDLE              = 4'd0,
    ST_ATTACK_ACTIVE     = 4'd4,
    ST_ATTACK_DIR_ACTIVE = 4'd7,
    ST_STUN              = 4'd9
  } char_state_e;

  typedef enum logic [1:0] {
    FS_NOHIT     = 2'b00,
    FS_HITSTUN   = 2'b01,
    FS_BLOCKSTUN = 2'b10
  } frame_state_e;

  localparam int AW = POS_W + 2;
  localparam logic [AW-1:0]    WIDTH_X = AW'(CHAR_WIDTH);
  localparam logic [AW-1:0]    GAP_X   = AW'(BODY_GAP);
  localparam logic [AW-1:0]    ATK_X   = AW'(ATK_REACH);
  localparam logic [AW-1:0]    DIR_X   = AW'(DIR_ATK_REACH);
  localparam logic [CNT_W-1:0] HIT_N   = CNT_W'(HITSTUN_FRAMES);
  localparam logic [CNT_W-1:0] BLK_N   = CNT_W'(BLOCKSTUN_FRAMES);

  logic [AW-1:0]    p1, p2, front1, reach1, reach2;
  logic             active1, active2, raw1, raw2, body;
  logic             elig1, elig2, valid1, valid2, trade;
  logic             latch1, latch2, kind1, kind2, hit1_q, hit2_q, col_q;
  logic [CNT_W-1:0] cnt1, cnt2, load1, load2;
  logic             kind1_nxt, kind2_nxt;

  // Everything is a sum compared against the other edge, so nothing can underflow.
  always_comb begin
    p1      = {2'b00, bus.char1_pos_x};
    p2      = {2'b00, bus.char2_pos_x};
    front1  = p1 + WIDTH_X;
    active1 = (bus.char1_state == ST_ATTACK_ACTIVE) || (bus.char1_state == ST_ATTACK_DIR_ACTIVE);
    active2 = (bus.char2_state == ST_ATTACK_ACTIVE) || (bus.char2_state == ST_ATTACK_DIR_ACTIVE);
    reach1  = (bus.char1_state == ST_ATTACK_DIR_ACTIVE) ? DIR_X : ATK_X;
    reach2  = (bus.char2_state == ST_ATTACK_DIR_ACTIVE) ? DIR_X : ATK_X;
    body    = (front1 + GAP_X) >= p2;
    raw1    = active1 && ((front1 + reach1) > p2);
    raw2    = active2 && (p2 < (front1 + reach2));
    elig1   = (cnt1 == '0) && (bus.char1_state != ST_STUN);
    elig2   = (cnt2 == '0) && (bus.char2_state != ST_STUN);
    valid1  = raw1 && !latch1 && elig2;
    valid2  = raw2 && !latch2 && elig1;
    trade   = valid1 && valid2;
    // A trade forces clean hitstun on both sides regardless of block.
    kind1_nxt = !trade && bus.char1_block_flag;
    kind2_nxt = !trade && bus.char2_block_flag;
    load1     = kind1_nxt ? BLK_N : HIT_N;
    load2     = kind2_nxt ? BLK_N : HIT_N;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= 1'b0;
      hit1_q <= 1'b0;
      hit2_q <= 1'b0;
      latch1 <= 1'b0;
      latch2 <= 1'b0;
      kind1  <= 1'b0;
      kind2  <= 1'b0;
      cnt1   <= '0;
      cnt2   <= '0;
    end else begin
      col_q  <= body;
      hit1_q <= valid1;
      hit2_q <= valid2;
      latch1 <= active1 && (latch1 || valid1);
      latch2 <= active2 && (latch2 || valid2);
      if (valid2) begin
        cnt1  <= load1;
        kind1 <= kind1_nxt;
      end else if (bus.frame_tick && cnt1 != '0) begin
        cnt1 <= cnt1 - 1'b1;
      end
      if (valid1) begin
        cnt2  <= load2;
        kind2 <= kind2_nxt;
      end else if (bus.frame_tick && cnt2 != '0) begin
        cnt2 <= cnt2 - 1'b1;
      end
    end
  end

  always_comb begin
    bus.collision_flag    = col_q;
    bus.char1_hit_o       = hit1_q;
    bus.char2_hit_o       = hit2_q;
    bus.char1_stun_cnt    = cnt1;
    bus.char2_stun_cnt    = cnt2;
    bus.char1_frame_state = (cnt1 == '0) ? FS_NOHIT : (kind1 ? FS_BLOCKSTUN : FS_HITSTUN);
    bus.char2_frame_state = (cnt2 == '0) ? FS_NOHIT : (kind2 ? FS_BLOCKSTUN : FS_HITSTUN);
  end

`ifdef HIT_COMBO_EN
  logic [1:0] since1, since2;
  logic [3:0] combo1, combo2;
  logic       end1, end2;

  always_comb begin
    end1 = bus.frame_tick && (cnt1 == CNT_W'(1)) && !valid2;
    end2 = bus.frame_tick && (cnt2 == CNT_W'(1)) && !valid1;
  end

  // since=3 means "no recent stun end"; it resets there so a first hit never chains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      since1 <= 2'd3;
      since2 <= 2'd3;
      combo1 <= '0;
      combo2 <= '0;
    end else begin
      if (end1) since1 <= '0;
      else if (bus.frame_tick && cnt1 == '0 && since1 != 2'd3) since1 <= since1 + 2'd1;
      if (end2) since2 <= '0;
      else if (bus.frame_tick && cnt2 == '0 && since2 != 2'd3) since2 <= since2 + 2'd1;
      if (trade) begin
        combo1 <= '0;
        combo2 <= '0;
      end else begin
        if (valid1) combo1 <= (since2 != 2'd3) ? ((combo1 == '1) ? combo1 : combo1 + 4'd1) : 4'd1;
        if (valid2) combo2 <= (since1 != 2'd3) ? ((combo2 == '1) ? combo2 : combo2 + 4'd1) : 4'd1;
      end
    end
  end

  always_comb begin
    bus.char1_combo = combo1;
    bus.char2_combo = combo2;
  end
`endif
endmodule
